// File: rtl/alu_func_encoder_if.sv
// Request/response handshake bundle for the ALU function encoder.
// The slave side is the encoder; the master side is control store / ALU.
interface alu_func_encoder_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_f;

   modport master (
      output in_valid, in_op, out_ready,
      input  in_ready, out_valid, out_f
   );

   modport slave (
      input  in_valid, in_op, out_ready,
      output in_ready, out_valid, out_f
   );
endinterface

// File: rtl/alu_func_encoder.sv
// One-hot ALU op request -> 2-bit function code, through a 2-entry queue.
// Illegal (non-one-hot) requests are consumed, flagged on err and counted.
module alu_func_encoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_func_encoder_if.slave     bus,
   output logic                  o_err,
   output logic [CNT_W-1:0]      o_op_count,
   output logic [CNT_W-1:0]      o_err_count
);

   localparam int unsigned F_W = 2;
   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       r_state;
   logic [F_W-1:0]   r_head;
   logic [F_W-1:0]   r_tail;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_err;
   logic [CNT_W-1:0] r_op_count;
   logic [CNT_W-1:0] r_err_count;

   logic [1:0]       w_state_nxt;
   logic [F_W-1:0]   w_head_nxt;
   logic [F_W-1:0]   w_tail_nxt;
   logic [F_W-1:0]   w_code;
   logic             w_legal;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_in_ready_nxt;
   logic             w_out_valid_nxt;

   // One-hot decode of the request
   always_comb begin
      w_code  = '0;
      w_legal = 1'b1;
      case (bus.in_op)
         4'b0001: w_code = 2'd0;
         4'b0010: w_code = 2'd1;
         4'b0100: w_code = 2'd2;
         4'b1000: w_code = 2'd3;
         default: w_legal = 1'b0;
      endcase
   end

   assign w_accept = bus.in_valid & r_in_ready;
   assign w_push   = w_accept & w_legal;
   assign w_pop    = r_out_valid & bus.out_ready;

   // Queue next-state; handshake outputs are precomputed so they can be registered
   always_comb begin
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      case (r_state)
         S_EMPTY: begin
            if (w_push) begin
               w_state_nxt = S_ONE;
               w_head_nxt  = w_code;
            end
         end
         S_ONE: begin
            if (w_push && w_pop) begin
               w_head_nxt = w_code;
            end else if (w_push) begin
               w_state_nxt = S_FULL;
               w_tail_nxt  = w_code;
            end else if (w_pop) begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_FULL: begin
            if (w_pop) begin
               w_state_nxt = S_ONE;
               w_head_nxt  = r_tail;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
      w_in_ready_nxt  = (w_state_nxt != S_FULL);
      w_out_valid_nxt = (w_state_nxt != S_EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_EMPTY;
         r_head      <= '0;
         r_tail      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_head      <= w_head_nxt;
         r_tail      <= w_tail_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   // Error pulse and saturating statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err       <= 1'b0;
         r_op_count  <= '0;
         r_err_count <= '0;
      end else begin
         r_err <= w_accept & ~w_legal;
         if (w_pop && (r_op_count != CNT_MAX)) begin
            r_op_count <= r_op_count + CNT_W'(1);
         end
         if (w_accept && !w_legal && (r_err_count != CNT_MAX)) begin
            r_err_count <= r_err_count + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_f     = r_head;
   assign o_err         = r_err;
   assign o_op_count    = r_op_count;
   assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_alu_func_encoder.sv
// Directed bench for alu_func_encoder; a second CNT_W=2 instance mirrors the
// same stimulus to exercise counter saturation.
module tb_alu_func_encoder;

   localparam int unsigned CNT_W     = 16;
   localparam int unsigned CNT_W_SAT = 2;

   logic clk;
   logic rst_n;
   logic                 err;
   logic [CNT_W-1:0]     op_count;
   logic [CNT_W-1:0]     err_count;
   logic                 s_err;
   logic [CNT_W_SAT-1:0] s_op_count;
   logic [CNT_W_SAT-1:0] s_err_count;

   int n_tests;
   int n_fail;

   alu_func_encoder_if bif ();
   alu_func_encoder_if sif ();

   assign sif.in_valid  = bif.in_valid;
   assign sif.in_op     = bif.in_op;
   assign sif.out_ready = bif.out_ready;

   alu_func_encoder #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bif.slave),
      .o_err       (err),
      .o_op_count  (op_count),
      .o_err_count (err_count)
   );

   alu_func_encoder #(.CNT_W(CNT_W_SAT)) dut_sat (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (sif.slave),
      .o_err       (s_err),
      .o_op_count  (s_op_count),
      .o_err_count (s_err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      bif.in_valid  = 1'b0;
      bif.in_op     = 4'b0000;
      bif.out_ready = 1'b0;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   logic [3:0] ops   [5];
   logic [1:0] codes [5];

   initial begin
      n_tests = 0;
      n_fail  = 0;

      // Reset held with a legal request pending
      rst_n = 1'b0;
      bif.in_valid  = 1'b1;
      bif.in_op     = 4'b0001;
      bif.out_ready = 1'b0;
      tick(3);
      check("rst_in_ready",  32'(bif.in_ready),  32'd1);
      check("rst_out_valid", 32'(bif.out_valid), 32'd0);
      check("rst_out_f",     32'(bif.out_f),     32'd0);
      check("rst_err",       32'(err),           32'd0);
      check("rst_op_count",  32'(op_count),      32'd0);
      check("rst_err_count", 32'(err_count),     32'd0);
      rst_n = 1'b1;
      tick();
      check("first_valid", 32'(bif.out_valid), 32'd1);
      check("first_f",     32'(bif.out_f),     32'd0);

      // Encoding sweep, back-to-back with out_ready high
      apply_reset();
      bif.out_ready = 1'b1;
      bif.in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bif.in_op = 4'b0001 << i;
         tick();
         check("sweep_valid", 32'(bif.out_valid), 32'd1);
         check("sweep_f",     32'(bif.out_f),     32'(i));
      end
      bif.in_valid = 1'b0;
      tick();
      check("sweep_drain_valid", 32'(bif.out_valid), 32'd0);
      check("sweep_op_count",    32'(op_count),      32'd4);

      // Backpressure: fill the queue, hold a third request
      apply_reset();
      bif.in_valid = 1'b1;
      bif.in_op    = 4'b0010;
      tick();
      bif.in_op    = 4'b1000;
      tick();
      check("bp_full_ready", 32'(bif.in_ready), 32'd0);
      check("bp_full_f",     32'(bif.out_f),    32'd1);
      bif.in_op    = 4'b0100;
      tick(2);
      check("bp_hold_ready", 32'(bif.in_ready),  32'd0);
      check("bp_hold_valid", 32'(bif.out_valid), 32'd1);
      check("bp_hold_f",     32'(bif.out_f),     32'd1);
      check("bp_hold_cnt",   32'(op_count),      32'd0);
      bif.out_ready = 1'b1;
      tick();
      check("bp_pop1_f",     32'(bif.out_f),    32'd3);
      check("bp_pop1_ready", 32'(bif.in_ready), 32'd1);
      tick();
      check("bp_pop2_f",     32'(bif.out_f),     32'd2);
      check("bp_pop2_valid", 32'(bif.out_valid), 32'd1);
      bif.in_valid = 1'b0;
      tick();
      check("bp_drain_valid", 32'(bif.out_valid), 32'd0);
      check("bp_op_count",    32'(op_count),      32'd3);

      // Illegal requests: zero and multi-hot
      apply_reset();
      bif.out_ready = 1'b1;
      bif.in_valid  = 1'b1;
      bif.in_op     = 4'b0000;
      tick();
      check("ill0_err",   32'(err),           32'd1);
      check("ill0_cnt",   32'(err_count),     32'd1);
      check("ill0_valid", 32'(bif.out_valid), 32'd0);
      bif.in_op = 4'b0110;
      tick();
      check("ill1_err",   32'(err),           32'd1);
      check("ill1_cnt",   32'(err_count),     32'd2);
      check("ill1_valid", 32'(bif.out_valid), 32'd0);
      bif.in_valid = 1'b0;
      tick();
      check("ill_err_clear", 32'(err),           32'd0);
      check("ill_err_count", 32'(err_count),     32'd2);
      check("ill_op_count",  32'(op_count),      32'd0);
      check("ill_out_f",     32'(bif.out_f),     32'd0);
      check("ill_ready",     32'(bif.in_ready),  32'd1);

      // Simultaneous push/pop in ONE; also drives the CNT_W=2 instance past saturation
      apply_reset();
      ops[0] = 4'b0100; codes[0] = 2'd2;
      ops[1] = 4'b0001; codes[1] = 2'd0;
      ops[2] = 4'b1000; codes[2] = 2'd3;
      ops[3] = 4'b0010; codes[3] = 2'd1;
      ops[4] = 4'b0100; codes[4] = 2'd2;
      bif.out_ready = 1'b1;
      bif.in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bif.in_op = ops[i];
         tick();
         check("pp_valid", 32'(bif.out_valid), 32'd1);
         check("pp_ready", 32'(bif.in_ready),  32'd1);
         check("pp_f",     32'(bif.out_f),     32'(codes[i]));
         check("pp_cnt",   32'(op_count),      32'(i));
      end
      bif.in_valid = 1'b0;
      tick();
      check("pp_op_count",  32'(op_count),   32'd5);
      check("sat_op_count", 32'(s_op_count), 32'd3);
      check("sat_err",      32'(s_err_count), 32'd0);

      // Asynchronous reset while FULL
      apply_reset();
      bif.out_ready = 1'b1;
      bif.in_valid  = 1'b1;
      bif.in_op     = 4'b1000;
      tick();
      bif.in_op     = 4'b0001;
      tick();
      bif.out_ready = 1'b0;
      bif.in_op     = 4'b0010;
      tick();
      check("mid_full_ready", 32'(bif.in_ready), 32'd0);
      check("mid_full_cnt",   32'(op_count),     32'd1);
      bif.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bif.out_valid), 32'd0);
      check("mid_rst_ready", 32'(bif.in_ready),  32'd1);
      check("mid_rst_cnt",   32'(op_count),      32'd0);
      tick();
      rst_n = 1'b1;
      bif.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mid_post_valid", 32'(bif.out_valid), 32'd0);
      end
      check("mid_post_cnt", 32'(op_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_func_encoder.md
Name: alu_func_encoder

Overview:
Inverse of the ALU function decoder: converts a one-hot operation request (ADD, OR, NOTB, SUM) into the 2-bit ALU function code f consumed by the decoder. Sits between the microsequencer/control store and the ALU. Requests enter through a valid/ready handshake and are buffered in a 2-entry queue. Encoded codes leave through a second valid/ready handshake. Illegal (non-one-hot) requests are rejected and counted.

Parameters:
CNT_W, 16, width of the op_count and err_count saturating counters (min 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request this cycle
in_op  input  4  one-hot op: bit0=ADD, bit1=OR, bit2=NOTB, bit3=SUM
out_valid  output  1  out_f holds a valid code
out_ready  input  1  downstream consumes out_f this cycle
out_f  output  2  encoded ALU function code
err  output  1  one-cycle pulse: an illegal request was accepted last cycle
op_count  output  CNT_W  legal ops delivered downstream, saturating
err_count  output  CNT_W  illegal requests accepted, saturating

Behaviour:
- Reset: asynchronous on rst_n low, released synchronously to clk. While rst_n is low and after release, outputs are in_ready=1, out_valid=0, out_f=2'h0, err=0, op_count=0, err_count=0. The queue is emptied.
- Encoding: 4'b0001->2'h0, 4'b0010->2'h1, 4'b0100->2'h2, 4'b1000->2'h3.
  - Any other in_op value (4'h0 or multi-hot) is illegal.
- Accept: occurs when in_valid && in_ready.
  - A legal accept writes the encoded code into the queue.
  - An illegal accept writes nothing. It sets err=1 for exactly the next cycle and increments err_count.
- Deliver: occurs when out_valid && out_ready. It pops the queue head and increments op_count.
- Queue FSM: EMPTY -> ONE -> FULL. Data is stored in two registers (head, tail).
  - EMPTY: in_ready=1, out_valid=0.
    - Legal accept -> ONE, with head = code.
  - ONE: in_ready=1, out_valid=1, out_f=head.
    - Legal accept without deliver -> FULL, with tail = code.
    - Deliver without legal accept -> EMPTY.
    - Deliver with legal accept -> stay in ONE, with head = new code.
  - FULL: in_ready=0, out_valid=1, out_f=head.
    - Deliver -> ONE, with head = tail.
    - in_valid is ignored in FULL. No same-cycle bypass when full.
- Latency: in EMPTY, a request accepted at edge k gives out_valid=1 with the code after edge k. There is no combinational path from in_* to out_*.
- in_ready depends only on state. It has no combinational dependence on out_ready.
- Output stability: while out_valid=1 and out_ready=0, out_f is held stable.
- In EMPTY, out_f keeps its last value; it is not meaningful.
- Counters saturate at all-ones and do not wrap.
- Illegal accepts never change queue state or out_f.
- Reset mid-operation: queued codes are discarded and counters clear. No partial delivery occurs after reset.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, in_op=4'b0001 -> in_ready=1, out_valid=0, counts=0. Release -> first accept, out_valid=1 and out_f=2'h0 one cycle later.
- Encoding sweep: with out_ready=1, send in_op 0001, 0010, 0100, 1000 back-to-back -> out_f = 0, 1, 2, 3 on consecutive cycles, each one cycle after its accept. op_count=4.
- Backpressure: out_ready=0, send OR then SUM.
  - Queue goes FULL and in_ready=0.
  - A third request (NOTB) is held and not accepted.
  - out_f stays 2'h1.
  - Raise out_ready -> out_f = 1, 3, 2 in order.
- Illegal inputs: send 4'h0, then 4'b0110 -> err pulses one cycle after each accept. err_count=2, out_valid stays 0, op_count=0.
- Simultaneous push/pop in ONE: each cycle in_valid=1 and out_ready=1 -> throughput of 1 op/cycle, state stays ONE, codes in order.
- Reset mid-operation: with queue FULL, assert rst_n=0 asynchronously between edges -> out_valid=0 immediately, counts=0. No stale code appears after release.
- Saturation: with CNT_W=2, deliver 5 legal ops -> op_count stays at 2'h3.
